// File: rtl/max_change_log.sv
// max_change_log: watches the tracker's per-cycle dout stream and logs every
// change as {value, sample index} into a small FIFO drained by valid/ready.
// Optional feature macro: MAX_CHANGE_LOG_DIR_EN (adds out_inc per entry).
module max_change_log #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int IDX_WIDTH  = 16
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [DATA_WIDTH-1:0]      din,
  input  logic                       din_valid,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_WIDTH-1:0]      out_data,
  output logic [IDX_WIDTH-1:0]       out_idx,
`ifdef MAX_CHANGE_LOG_DIR_EN
  output logic                       out_inc,
`endif
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
`ifdef MAX_CHANGE_LOG_DIR_EN
  localparam int ENTRY_W = DATA_WIDTH + IDX_WIDTH + 1;
`else
  localparam int ENTRY_W = DATA_WIDTH + IDX_WIDTH;
`endif

  logic [ENTRY_W-1:0]    mem [DEPTH];
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_next;
  logic [CNT_W-1:0]      count_q;
  logic [CNT_W-1:0]      count_next;
  logic [DATA_WIDTH-1:0] prev;
  logic [IDX_WIDTH-1:0]  idx;
  logic [ENTRY_W-1:0]    head_q;
  logic [ENTRY_W-1:0]    head_next;
  logic [ENTRY_W-1:0]    entry;
  logic                  evt;
  logic                  full;
  logic                  pop;
  logic                  push;
  logic                  drop;

  // Event detection, push/pop arbitration and the next head entry.
  // The head is kept in its own register so the outputs hold their last
  // value when the FIFO drains empty instead of showing a stale slot.
  always_comb begin
    evt  = din_valid && (din != prev);
    full = (count_q == CNT_W'(DEPTH));
    pop  = (count_q != '0) && out_ready;
    push = evt && (!full || pop);
    drop = evt && full && !pop;
`ifdef MAX_CHANGE_LOG_DIR_EN
    entry = {din > prev, din, idx};
`else
    entry = {din, idx};
`endif
    rd_next    = pop ? rd_ptr + 1'b1 : rd_ptr;
    count_next = count_q;
    if (push && !pop) count_next = count_q + CNT_W'(1);
    if (pop && !push) count_next = count_q - CNT_W'(1);
    head_next = head_q;
    if (count_next != '0) begin
      // rd_next meets wr_ptr with a push only when the new entry becomes head
      if (push && (rd_next == wr_ptr)) head_next = entry;
      else                             head_next = mem[rd_next];
    end
  end

  // Entry storage; contents are only observed through head_q.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= entry;
  end

  // Pointers, occupancy, head register, sample tracking and sticky overflow.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count_q  <= '0;
      head_q   <= '0;
      prev     <= '0;
      idx      <= '0;
      overflow <= 1'b0;
    end else begin
      rd_ptr  <= rd_next;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      count_q <= count_next;
      head_q  <= head_next;
      if (din_valid) begin
        prev <= din;
        idx  <= idx + 1'b1;
      end
      if (drop) overflow <= 1'b1;
    end
  end

  assign out_valid = (count_q != '0);
  assign count     = count_q;
  assign out_data  = head_q[IDX_WIDTH +: DATA_WIDTH];
  assign out_idx   = head_q[IDX_WIDTH-1:0];
`ifdef MAX_CHANGE_LOG_DIR_EN
  assign out_inc   = head_q[ENTRY_W-1];
`endif

endmodule

// File: tb/tb_max_change_log.sv
// Bench for max_change_log: a queue-based model checked every cycle, plus
// literal expectations on the drained entry sequence for each scenario.
module tb_max_change_log;

  localparam int DW = 32;
  localparam int DP = 4;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [DW-1:0] din = '0;
  logic          din_valid = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [IW-1:0] out_idx;
  logic [2:0]    count;
  logic          overflow;
  logic          out_inc_w;

  max_change_log #(.DATA_WIDTH(DW), .DEPTH(DP), .IDX_WIDTH(IW)) dut (
    .clk(clk),
    .resetn(resetn),
    .din(din),
    .din_valid(din_valid),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_idx(out_idx),
`ifdef MAX_CHANGE_LOG_DIR_EN
    .out_inc(out_inc_w),
`endif
    .count(count),
    .overflow(overflow)
  );

`ifndef MAX_CHANGE_LOG_DIR_EN
  assign out_inc_w = 1'b0;
`endif

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    logic [IW-1:0] i;
    logic          inc;
  } ent_t;

  ent_t          mq[$];
  ent_t          dlog[$];
  logic [DW-1:0] m_prev;
  logic [IW-1:0] m_idx;
  logic          m_ovf;
  int            tests = 0;
  int            errs = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the log is a queue; an event is a valid sample differing from
  // the previous valid sample; a full queue drops the event unless the
  // head leaves the same cycle.
  always @(negedge resetn) begin
    mq.delete();
    m_prev = '0;
    m_idx  = '0;
    m_ovf  = 1'b0;
  end

  always @(posedge clk) begin
    if (resetn) begin
      ent_t e;
      bit   mpop;
      if (out_valid && out_ready) begin
        e.d = out_data; e.i = out_idx; e.inc = out_inc_w;
        dlog.push_back(e);
      end
      mpop = (mq.size() > 0) && out_ready;
      if (mpop) void'(mq.pop_front());
      if (din_valid) begin
        if (din != m_prev) begin
          if (mq.size() < DP) begin
            e.d = din; e.i = m_idx; e.inc = (din > m_prev);
            mq.push_back(e);
          end else begin
            m_ovf = 1'b1;
          end
        end
        m_prev = din;
        m_idx  = m_idx + 1'b1;
      end
    end
    #2;
    if (resetn) begin
      chk("out_valid", DW'(out_valid), DW'(mq.size() != 0));
      chk("count", DW'(count), DW'(mq.size()));
      chk("overflow", DW'(overflow), DW'(m_ovf));
      if (mq.size() != 0) begin
        chk("out_data", out_data, mq[0].d);
        chk("out_idx", DW'(out_idx), DW'(mq[0].i));
`ifdef MAX_CHANGE_LOG_DIR_EN
        chk("out_inc", DW'(out_inc_w), DW'(mq[0].inc));
`endif
      end
    end
  end

  task automatic drive(input logic v, input logic [DW-1:0] d);
    @(negedge clk);
    din_valid = v;
    din = d;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      din_valid = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    din_valid = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    dlog.delete();
  endtask

  task automatic check_log(input string name, input int n,
                           input logic [DW-1:0] ed [10], input logic [IW-1:0] ei [10]);
    chk({name, "_len"}, DW'(dlog.size()), DW'(n));
    for (int k = 0; k < n && k < dlog.size(); k++) begin
      chk({name, "_data"}, dlog[k].d, ed[k]);
      chk({name, "_idx"}, DW'(dlog[k].i), DW'(ei[k]));
    end
  endtask

  initial begin
    // reset state while held in reset
    #3;
    chk("rst_valid", DW'(out_valid), '0);
    chk("rst_count", DW'(count), '0);
    chk("rst_ovf", DW'(overflow), '0);
    chk("rst_data", out_data, '0);
    chk("rst_idx", DW'(out_idx), '0);
    @(negedge clk);
    resetn = 1'b1;

    // basic logging
    do_reset();
    out_ready = 1'b1;
    drive(1, 0); drive(1, 0); drive(1, 2); drive(1, 2); drive(1, 6); drive(1, 6);
    idle(3);
    check_log("basic", 2, '{2, 6, 0, 0, 0, 0, 0, 0, 0, 0}, '{2, 4, 0, 0, 0, 0, 0, 0, 0, 0});
    chk("basic_ovf", DW'(overflow), '0);

    // gaps in valid
    do_reset();
    out_ready = 1'b1;
    drive(1, 3); drive(0, 32'hdead); drive(0, 32'hbeef); drive(1, 3); drive(1, 5);
    idle(3);
    check_log("gaps", 2, '{3, 5, 0, 0, 0, 0, 0, 0, 0, 0}, '{0, 2, 0, 0, 0, 0, 0, 0, 0, 0});

    // backpressure and overflow
    do_reset();
    drive(1, 1); drive(1, 2); drive(1, 3); drive(1, 4); drive(1, 5);
    idle(1);
    chk("ovf_count", DW'(count), 4);
    chk("ovf_flag", DW'(overflow), 1);
    out_ready = 1'b1;
    idle(6);
    check_log("ovf", 4, '{1, 2, 3, 4, 0, 0, 0, 0, 0, 0}, '{0, 1, 2, 3, 0, 0, 0, 0, 0, 0});
    chk("ovf_sticky", DW'(overflow), 1);

    // full with simultaneous pop
    do_reset();
    drive(1, 1); drive(1, 2); drive(1, 3); drive(1, 4);
    @(negedge clk);
    din = 9; din_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    din_valid = 1'b0; out_ready = 1'b0;
    chk("fullpop_count", DW'(count), 4);
    chk("fullpop_ovf", DW'(overflow), 0);
    out_ready = 1'b1;
    idle(6);
    check_log("fullpop", 5, '{1, 2, 3, 4, 9, 0, 0, 0, 0, 0}, '{0, 1, 2, 3, 4, 0, 0, 0, 0, 0});

    // reset mid-operation
    do_reset();
    drive(1, 1); drive(1, 2); drive(1, 3);
    idle(1);
    chk("mid_pre_count", DW'(count), 3);
    #2 resetn = 1'b0;
    #1;
    chk("mid_valid", DW'(out_valid), 0);
    chk("mid_count", DW'(count), 0);
    #1 resetn = 1'b1;
    dlog.delete();
    out_ready = 1'b1;
    drive(1, 7);
    idle(3);
    check_log("mid", 1, '{7, 0, 0, 0, 0, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0});

    // index wrap with 3-bit index
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 9; k++) drive(1, (k % 2 == 0) ? 1 : 0);
    idle(3);
    check_log("wrap", 9, '{1, 0, 1, 0, 1, 0, 1, 0, 1, 0}, '{0, 1, 2, 3, 4, 5, 6, 7, 0, 0});

`ifdef MAX_CHANGE_LOG_DIR_EN
    // direction flag
    do_reset();
    out_ready = 1'b1;
    drive(1, 4); drive(1, 2); drive(1, 9);
    idle(3);
    check_log("dir", 3, '{4, 2, 9, 0, 0, 0, 0, 0, 0, 0}, '{0, 1, 2, 0, 0, 0, 0, 0, 0, 0});
    if (dlog.size() == 3) begin
      chk("dir_inc0", DW'(dlog[0].inc), 1);
      chk("dir_inc1", DW'(dlog[1].inc), 0);
      chk("dir_inc2", DW'(dlog[2].inc), 1);
    end
`endif

    idle(2);
    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end

endmodule

// File: doc/max_change_log.md
Name: max_change_log

Overview:
- Downstream consumer of the second-largest tracker (`model`). Samples the tracker's `dout` stream and detects every change in the tracked value.
- Each change is logged as an entry {value, sample index} in a small FIFO.
- Entries drain through a valid/ready interface to the debug/readout logic.
- Converts a per-cycle level stream into a sparse event stream, so software sees only updates.

Parameters:
- DATA_WIDTH, 32, width of tracked value (matches upstream tracker).
- DEPTH, 4, FIFO entries; power of 2, >= 2.
- IDX_WIDTH, 16, width of the sample index counter.

Ports:
- clk  input  1  clock, all logic on rising edge.
- resetn  input  1  asynchronous active-low reset.
- din  input  DATA_WIDTH  tracked value from upstream tracker `dout`.
- din_valid  input  1  din is a valid sample this cycle.
- out_valid  output  1  head entry available.
- out_ready  input  1  consumer accepts head entry.
- out_data  output  DATA_WIDTH  value of head entry.
- out_idx  output  IDX_WIDTH  sample index of head entry.
- count  output  $clog2(DEPTH)+1  current number of entries.
- overflow  output  1  sticky flag: an event was dropped.

Behaviour:
- Reset (async assert, sync release): `prev`=0, `idx`=0, FIFO empty, count=0, out_valid=0, out_data=0, out_idx=0, overflow=0.
- Sample accept: a cycle with din_valid=1. din_valid=0 cycles are ignored entirely (no idx change, no compare).
- idx: index of the current accepted sample, starting at 0 after reset. Increments by 1 after each accepted sample. Wraps modulo 2^IDX_WIDTH, with no flag on wrap.
- Event: accepted sample with din != prev. `prev` updates to din on every accepted sample.
  - Since prev resets to 0, a leading zero stream produces no events.
- Push: on an event, write {din, idx-of-this-sample} at the tail.
- Pop: occurs when out_valid && out_ready; head advances.
- Latency: an event accepted in cycle N is visible (out_valid=1) at cycle N+1. There is no combinational bypass from din to out_*.
- out_valid = (count != 0). out_data/out_idx show the head entry. They are held stable while out_valid && !out_ready.
- When empty: out_data/out_idx hold their last values, and are don't-care to the consumer.
- Full (count==DEPTH):
  - Event with pop in the same cycle: push and pop both happen, count unchanged.
  - Event without pop: event dropped and overflow set to 1. FIFO contents unchanged; prev and idx still update.
- overflow clears only on reset.
- Empty with event and out_ready=1: no pop (nothing to pop); push only, count becomes 1.
- Pointers: read and write pointers are $clog2(DEPTH) bits and wrap naturally. count tracks occupancy, 0..DEPTH.
- Reset mid-operation: all entries discarded immediately. A handshake in flight is abandoned, and out_valid drops asynchronously.

Optional Feature:
- Macro: MAX_CHANGE_LOG_DIR_EN.
- Defined:
  - Extra output out_inc (1 bit) = 1 if the logged value is greater than the previous tracked value (unsigned compare), else 0.
  - Stored per entry, so the FIFO width grows by 1.
  - Reset value of out_inc is 0.
- Undefined: no out_inc port and no compare logic; FIFO width is DATA_WIDTH+IDX_WIDTH.

Test Plan:
- Basic logging: din_valid=1, din=0,0,2,2,6,6, out_ready=1 → two entries: (2, idx=2) then (6, idx=4). Each out_valid asserts one cycle after the sample; overflow stays 0.
- Gaps in valid: din 3 (valid), X (din_valid=0, 2 cycles), 3, 5 → one entry (3, idx=0) and one entry (5, idx=2). Invalid cycles neither count nor compare.
- Backpressure/overflow (DEPTH=4): out_ready=0; din=1,2,3,4,5 → count=4, overflow=1. Then out_ready=1 drains (1,0),(2,1),(3,2),(4,3) in order; value 5 is absent.
- Full with simultaneous pop: FIFO holds 4 entries; in one cycle din changes and out_ready=1 → count stays 4, overflow stays 0, new entry is last out.
- Reset mid-operation: 3 entries queued, out_ready=0; pulse resetn low between clock edges → out_valid=0 and count=0 immediately. After release, din=7 → entry (7, idx=0).
- Index wrap (IDX_WIDTH=3): 9 accepted samples alternating 1,0 → logged indices 0,1,…,7,0.
- MAX_CHANGE_LOG_DIR_EN defined: din=4,2,9 → out_inc sequence 1,0,1.
